spi_responder: RTL
==================

SPI_RESPONDER -- requirements
Module: spi_responder

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchronizer flop depth on spi_sclk, spi_mosi and spi_ss_n; legal values 2..3.
REQ-002 clk_clk  in  1  system clock; all logic on its rising edge.
REQ-003 reset_reset_n  in  1  reset; synchronous, active-low.
REQ-004 spi_sclk  in  1  SPI clock from the master; mode 0 (CPOL=0, CPHA=0).
REQ-005 spi_mosi  in  1  master-out data, MSB first.
REQ-006 spi_ss_n  in  1  slave select, active-low.
REQ-007 spi_miso  out  1  slave-out data; driven 0 while deselected.
REQ-008 spi_miso_oe  out  1  high while selected; used for the pad tri-state.
REQ-009 status_in  in  8  status byte returned during every command byte.
REQ-010 local_addr  in  5  local read address into the register file.
REQ-011 local_rdata  out  8  registered read data, valid 1 cycle after local_addr.
REQ-012 wr_strobe  out  1  one-cycle pulse per SPI-written data byte.
REQ-013 wr_addr  out  5  register address of the write; valid with wr_strobe.
REQ-014 wr_data  out  8  data byte of the write; valid with wr_strobe.
REQ-015 frame_err  out  1  one-cycle pulse when a frame ends mid-byte.

Function
REQ-016 Storage: 32 x 8 register file; the SPI side writes it, the SPI and local sides read it.
REQ-017 Synchronization: the SPI inputs pass through SYNC_STAGES flops; edges are detected on the synchronized values only.
REQ-018 Timing constraint: the spi_sclk high and low phases are each at least 4 clk_clk periods.
REQ-019 Mode 0 bit timing: sample MOSI on each detected SCLK rise; shift out the next MISO bit on each detected SCLK fall.
REQ-020 FSM states: IDLE, CMD, DATA.
REQ-021 IDLE -> CMD on a synchronized SS_n fall; in the same cycle load status_in into the MISO shifter, drive bit 7, clear the 3-bit bit counter, assert spi_miso_oe.
REQ-022 Command byte format: bits[7:3] = start address, bit[1] = direction (1 = write, 0 = read), bits[2] and [0] ignored.
REQ-023 CMD -> DATA after the 8th sampled bit; latch the address pointer and direction.
REQ-024 On entering DATA for a read, load reg[pointer] into the MISO shifter before the next SCLK fall.
REQ-025 DATA read: after each 8th bit, increment the pointer, then load reg[pointer] for the next byte.
REQ-026 DATA write: after each 8th bit, write reg[pointer] <= received byte.
REQ-027 DATA write, same cycle as the register write: pulse wr_strobe with wr_addr = pointer and wr_data = byte, then increment the pointer.
REQ-028 The pointer is 5 bits and wraps 31 -> 0 with no error.
REQ-029 Any state -> IDLE on a synchronized SS_n rise; spi_miso_oe deasserts and spi_miso goes to 0 in the same cycle.
REQ-030 SS_n rise with bit counter != 0: discard the partial byte, perform no write and no wr_strobe, pulse frame_err for 1 cycle.
REQ-031 SS_n rise on a byte boundary (counter == 0): frame_err stays low.
REQ-032 SCLK edges while SS_n is high are ignored.
REQ-033 A frame holding only the command byte performs no access.
REQ-034 SS_n rise coincident with the 8th-bit sample: the byte completes first (write/strobe), then IDLE; frame_err stays low.
REQ-035 Local read and SPI write to the same address in the same cycle: local_rdata returns the old value, and the new value appears on the following read.
REQ-036 Latency: wr_strobe occurs at most 2 clk_clk cycles after the synchronized 8th SCLK rise.

Reset
REQ-037 While reset_reset_n = 0 at a clk_clk edge, the following take their reset values: FSM = IDLE, all register file entries = 0x00, pointer = 0, bit counter = 0, shifters = 0.
REQ-038 Reset output values: spi_miso = 0, spi_miso_oe = 0, local_rdata = 0x00, wr_strobe = 0, wr_addr = 0, wr_data = 0x00, frame_err = 0.
REQ-039 Reset mid-frame aborts the frame with no write and no frame_err.
REQ-040 After reset release, the next SS_n fall is required before any bit is accepted.

Verification
REQ-041 Write burst: cmd 0x1A (addr 3, write), data 0x11, 0x22 -> wr_strobe twice, (3, 0x11) then (4, 0x22); local_addr 4 -> local_rdata 0x22.
REQ-042 Read burst: reg 7 = 0xA5, reg 8 = 0x5A, status_in = 0xC3; cmd 0x38 then 2 dummy bytes -> MISO returns 0xC3, 0xA5, 0x5A.
REQ-043 Wrap-around: cmd 0xFA (addr 31, write), data 0x01, 0x02 -> reg31 = 0x01, reg0 = 0x02.
REQ-044 Aborted frame: cmd 0x12, then 5 data bits, then SS_n high -> no wr_strobe, one frame_err pulse, reg2 unchanged.
REQ-045 Reset mid-write at bit 4 -> all outputs at reset values, reg file all 0x00; a following full write of 0x33 to addr 0 succeeds.
REQ-046 Same-cycle conflict: local read of addr 5 coincident with the SPI write of 0x99 to addr 5 -> old value returned, then 0x99.

Source files
------------

// File: rtl/spi_responder.sv
// SPI mode-0 responder fronting a 32 x 8 register file: a command byte selects
// start address and direction, then data bytes stream in or out with auto-increment.
module spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_ss_n,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] status_in,
  input  logic [4:0] local_addr,
  output logic [7:0] local_rdata,
  output logic       wr_strobe,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       frame_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic [SYNC_STAGES-1:0] ss_sync_q;
  logic                   sclk_prev_q;
  logic                   ss_prev_q;

  logic       sclk_s, mosi_s, ss_s;
  logic       sclk_rise_s, sclk_fall_s, ss_fall_s, ss_rise_s;
  logic [7:0] rx_byte_s;
  logic [4:0] ptr_inc_s;
  logic       reg_we_s;

  logic [1:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [4:0] ptr_q, ptr_d;
  logic       dir_q, dir_d;
  logic       miso_q, miso_d;
  logic       oe_q, oe_d;
  logic       wr_strobe_q, wr_strobe_d;
  logic [4:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       frame_err_q, frame_err_d;
  logic [7:0] local_rdata_q;
  logic [7:0] regs_q [32];

  // Select syncs reset low so a select already held low at reset release is not seen as a fall.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sclk_sync_q <= {SYNC_STAGES{1'b0}};
      mosi_sync_q <= {SYNC_STAGES{1'b0}};
      ss_sync_q   <= {SYNC_STAGES{1'b0}};
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], spi_ss_n};
      sclk_prev_q <= sclk_s;
      ss_prev_q   <= ss_s;
    end
  end

  assign sclk_s      = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s      = mosi_sync_q[SYNC_STAGES-1];
  assign ss_s        = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_s & ~sclk_prev_q;
  assign sclk_fall_s = ~sclk_s & sclk_prev_q;
  assign ss_fall_s   = ~ss_s & ss_prev_q;
  assign ss_rise_s   = ss_s & ~ss_prev_q;
  assign rx_byte_s   = {rx_sh_q[6:0], mosi_s};
  assign ptr_inc_s   = ptr_q + 5'd1;

  // Frame sequencing; a completing byte is processed before a coincident deselect.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_sh_d     = rx_sh_q;
    tx_sh_d     = tx_sh_q;
    ptr_d       = ptr_q;
    dir_d       = dir_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    reg_we_s    = 1'b0;
    if (state_q == ST_IDLE) begin
      if (ss_fall_s) begin
        state_d   = ST_CMD;
        miso_d    = status_in[7];
        tx_sh_d   = {status_in[6:0], 1'b0};
        rx_sh_d   = 8'h00;
        bit_cnt_d = 3'd0;
        oe_d      = 1'b1;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      if (sclk_rise_s) begin
        rx_sh_d   = rx_byte_s;
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          case (state_q)
            ST_CMD: begin
              state_d = ST_DATA;
              dir_d   = rx_byte_s[1];
              ptr_d   = rx_byte_s[7:3];
              tx_sh_d = rx_byte_s[1] ? 8'h00 : regs_q[rx_byte_s[7:3]];
            end
            ST_DATA: begin
              if (dir_q) begin
                reg_we_s    = 1'b1;
                wr_strobe_d = 1'b1;
                wr_addr_d   = ptr_q;
                wr_data_d   = rx_byte_s;
                tx_sh_d     = 8'h00;
              end else begin
                tx_sh_d = regs_q[ptr_inc_s];
              end
              ptr_d = ptr_inc_s;
            end
            default: state_d = ST_IDLE;
          endcase
        end else begin
          state_d = state_q;
        end
      end else if (sclk_fall_s) begin
        miso_d  = tx_sh_q[7];
        tx_sh_d = {tx_sh_q[6:0], 1'b0};
      end else begin
        miso_d = miso_q;
      end
      if (ss_rise_s) begin
        state_d     = ST_IDLE;
        oe_d        = 1'b0;
        miso_d      = 1'b0;
        frame_err_d = (bit_cnt_d != 3'd0);
        bit_cnt_d   = 3'd0;
        rx_sh_d     = 8'h00;
        tx_sh_d     = 8'h00;
      end else begin
        oe_d = oe_q;
      end
    end
  end

  // Control and output registers.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_sh_q     <= 8'h00;
      tx_sh_q     <= 8'h00;
      ptr_q       <= 5'd0;
      dir_q       <= 1'b0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= 5'd0;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_sh_q     <= rx_sh_d;
      tx_sh_q     <= tx_sh_d;
      ptr_q       <= ptr_d;
      dir_q       <= dir_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Register file; the local port reads pre-write contents on a same-cycle collision.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 8'h00;
      end
      local_rdata_q <= 8'h00;
    end else begin
      if (reg_we_s) begin
        regs_q[ptr_q] <= rx_byte_s;
      end
      local_rdata_q <= regs_q[local_addr];
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign wr_strobe   = wr_strobe_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_err   = frame_err_q;
  assign local_rdata = local_rdata_q;

endmodule
